// File: rtl/voice_mixer.sv
// Sums the active voices' 10-bit samples and scales the sum onto the codec's 32-bit left/right channels.
// Latency: the frame registers one edge after the last required sample; codec_write can assert in the cycle that follows.
// Backpressure: voice_allowed drops per voice once its sample is held and for all voices while a frame waits on codec_allowed.
module voice_mixer #(
    parameter int SAMPLE_W   = 10,
    parameter int OUT_W      = 32,
    parameter int GAIN_SHIFT = 20
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          voice_active,
    input  logic [2:0]          voice_write,
    input  logic [2:0]          voice_clear,
    input  logic [SAMPLE_W-1:0] voice_sample0,
    input  logic [SAMPLE_W-1:0] voice_sample1,
    input  logic [SAMPLE_W-1:0] voice_sample2,
    output logic [2:0]          voice_allowed,
    input  logic                codec_allowed,
    output logic                codec_write,
    output logic                codec_clear,
    output logic [OUT_W-1:0]    left_out,
    output logic [OUT_W-1:0]    right_out,
    output logic                overrun
);

    // Three sign-extended samples cannot overflow two extra bits.
    localparam int MIX_W = SAMPLE_W + 2;

    typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [2:0]          valid, valid_nxt;
    logic [2:0]          accept;
    logic                ready;
    logic [SAMPLE_W-1:0] sample_in [3];
    logic [SAMPLE_W-1:0] hold      [3];
    logic [MIX_W-1:0]    mix_sum;
    logic [OUT_W-1:0]    mix_ext;
    logic [OUT_W-1:0]    scaled;

    assign sample_in[0] = voice_sample0;
    assign sample_in[1] = voice_sample1;
    assign sample_in[2] = voice_sample2;

    // A frame is ready once every active voice holds a sample; with no voice active there is nothing to send.
    assign ready  = (&(valid | ~voice_active)) & (|voice_active);
    assign accept = voice_write & voice_allowed;

    // Right channel is a mirror of the left; the codec gets mono on both sides.
    assign right_out = left_out;

    // Handshake outputs and next state; reset masks both strobes so a frame caught mid-SEND is never written.
    always_comb begin
        state_nxt     = state;
        codec_write   = 1'b0;
        voice_allowed = 3'b000;
        if (!reset) begin
            if (state == COLLECT) begin
                voice_allowed = ~valid;
                if (ready) state_nxt = SEND;
            end else begin
                codec_write = codec_allowed;
                if (codec_allowed) state_nxt = COLLECT;
            end
        end
    end

    // Valid-bit update: clear beats everything, frame completion and inactive-voice cleanup beat a new write.
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) valid_nxt[i] = 1'b1;
            if ((state == COLLECT) && ready && !voice_active[i]) valid_nxt[i] = 1'b0;
            if (codec_write) valid_nxt[i] = 1'b0;
            if (voice_clear[i]) valid_nxt[i] = 1'b0;
        end
    end

    // Sum of active voices, sign-extended to the codec width and scaled up by the gain shift.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < 3; i++) begin
            if (voice_active[i])
                mix_sum = mix_sum + {{2{hold[i][SAMPLE_W-1]}}, hold[i]};
        end
        mix_ext = {{(OUT_W-MIX_W){mix_sum[MIX_W-1]}}, mix_sum};
        scaled  = mix_ext << GAIN_SHIFT;
    end

    // State, per-voice holding registers, frame output and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= COLLECT;
            valid       <= 3'b000;
            left_out    <= '0;
            codec_clear <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < 3; i++) hold[i] <= '0;
        end else begin
            state       <= state_nxt;
            valid       <= valid_nxt;
            codec_clear <= |voice_clear;
            if (|(voice_write & ~voice_allowed)) overrun <= 1'b1;
            if ((state == COLLECT) && ready) left_out <= scaled;
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) hold[i] <= sample_in[i];
            end
        end
    end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Downstream stage of the per-key sound players; sits between the three voice players and the audio codec controller.
- Collects one 10-bit signed sample from each active voice, sums them, and scales the sum to the codec's 32-bit sample width.
- Drives the codec write handshake with identical left/right data and generates the per-voice audio_out_allowed back-pressure.

Parameters:
- SAMPLE_W, 10, width of each voice sample (signed two's complement).
- OUT_W, 32, codec channel width.
- GAIN_SHIFT, 20, left shift applied to the sum; legal range 0..(OUT_W-SAMPLE_W-2). 20 fills 32 bits exactly.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- voice_active  in  3  voice i participates in the mix when bit i = 1.
- voice_write  in  3  per-voice write_audio_out strobe.
- voice_clear  in  3  per-voice clear_buffer request.
- voice_sample0  in  SAMPLE_W  voice 0 audio_out.
- voice_sample1  in  SAMPLE_W  voice 1 audio_out.
- voice_sample2  in  SAMPLE_W  voice 2 audio_out.
- voice_allowed  out  3  per-voice audio_out_allowed.
- codec_allowed  in  1  codec FIFO has room (audio_out_allowed from the codec).
- codec_write  out  1  codec write strobe.
- codec_clear  out  1  codec clear request.
- left_out  out  OUT_W  left sample.
- right_out  out  OUT_W  right sample; always equals left_out.
- overrun  out  1  sticky flag: a voice write was dropped.

Behaviour:
- Reset: state=COLLECT, all hold registers=0, valid[2:0]=0, left_out=right_out=0, codec_clear=0, overrun=0.
- Per-voice holding register plus valid bit.
- voice_allowed[i] = ~valid[i] & (state==COLLECT). This is combinational; it is forced to 0 while reset=1.
- Write accept:
  - voice_write[i] & voice_allowed[i] latches sample i and sets valid[i] on the same edge.
  - voice_write[i] when not allowed: sample is dropped and overrun is set to 1. overrun stays 1 until reset.
- Clear: voice_clear[i] clears valid[i] on that edge and has priority over a simultaneous write from voice i. codec_clear = registered OR of voice_clear (1-cycle latency).
- FSM:
  - COLLECT: ready = &(valid | ~voice_active) & (|voice_active).
    - When ready, register mix = sum over active i of sign-extended sample i (SAMPLE_W+2 bits, no overflow possible).
    - left_out/right_out = sign-extend(mix) << GAIN_SHIFT, truncated to OUT_W. Next state is SEND.
    - Inactive voices contribute 0. Their valid bits are ignored and then cleared.
    - With voice_active==0 the FSM stays in COLLECT and outputs hold.
  - SEND: codec_write = codec_allowed (combinational, only in SEND). left_out/right_out stay stable for the whole SEND.
    - On the edge where codec_write=1: valid[2:0] cleared and next state is COLLECT.
    - codec_allowed low: remain in SEND indefinitely; voice_allowed stays 0.
- Latency: the last required sample is accepted at edge N. Outputs are valid and the FSM is in SEND after edge N+1. codec_write is asserted from cycle N+1 if codec_allowed=1.
- A voice deactivated mid-COLLECT is excluded immediately. A voice activated mid-COLLECT becomes required.
- Reset mid-SEND: the frame is discarded, no codec_write follows, and the block returns to the reset state next edge.
- left_out/right_out hold their last frame value in COLLECT; they are never reset except by reset.

Test Plan:
- Reset asserted 3 cycles, then released → voice_allowed=3'b111, codec_write=0, left_out=0, overrun=0.
- Active=111; write samples 100, -50, 200; codec_allowed=1 → after 1 cycle, codec_write pulses exactly 1 cycle; left_out=right_out=0x0FA00000; voice_allowed returns to 111 next cycle.
- Extremes: all -512 → 0xA0000000; all +511 → 0x5FD00000.
- Active=001; voice0 writes 7 while voices 1/2 write garbage → left_out=0x00700000. Voices 1/2 do not block the frame.
- Frame ready with codec_allowed held low 10 cycles → left_out stable, voice_allowed=000, codec_write=0. Raise codec_allowed → single write.
- Voice0 writes twice before the frame completes → overrun=1 and stays 1. Clear voice1 with a simultaneous write → valid[1]=0 and codec_clear=1 the next cycle. Assert reset while in SEND → no codec_write, all outputs at reset values.
